nrf24_event_tx_scheduler: RTL

//  Multi-channel successor of the single-switch nRF24 TX requester. Synchronises N_CH async capture

---
 rtl/nrf24_tx_pkg.sv | 24 ++
 rtl/nrf24_cap_sync_edge.sv | 45 ++++
 rtl/nrf24_event_tx_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nrf24_tx_pkg.sv
// Shared types for the nRF24 event TX scheduler: FSM states and the one-byte payload layout.
package nrf24_tx_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  localparam int unsigned CH_MSB  = 7;
  localparam int unsigned CH_LSB  = 4;
  localparam int unsigned SEQ_MSB = 3;
  localparam int unsigned SEQ_LSB = 1;
  localparam int unsigned LVL_BIT = 0;

  typedef logic [7:0] payload_t;

  function automatic payload_t make_payload(input logic [3:0] ch, input logic [2:0] seq,
                                            input logic lvl);
    payload_t p;
    p                  = '0;
    p[CH_MSB:CH_LSB]   = ch;
    p[SEQ_MSB:SEQ_LSB] = seq;
    p[LVL_BIT]         = lvl;
    return p;
  endfunction

endpackage

// File: rtl/nrf24_cap_sync_edge.sv
// One capture channel: synchroniser, two-way edge detect and a refresh timer while held high.
module nrf24_cap_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REFRESH_CYC = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic cap,
  input  logic send,
  output logic lvl,
  output logic evt
);

  localparam int unsigned TW = $clog2(REFRESH_CYC + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_q;
  logic [TW-1:0]          timer;
  logic                   s;
  logic                   edge_det;
  logic                   refresh;

  assign s        = sync[SYNC_STAGES-1];
  assign edge_det = s ^ s_q;
  assign refresh  = s && (timer == TW'(REFRESH_CYC - 1));
  assign lvl      = s;
  assign evt      = edge_det | refresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      s_q   <= 1'b0;
      timer <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], cap};
      s_q  <= s;
      // wrapping on refresh keeps the timer bounded even if the send is delayed
      if (!s || edge_det || send || refresh)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/nrf24_event_tx_scheduler.sv
// Multi-channel event scheduler: round-robin one-byte payloads into the nRF24 TX controller
// over a tx_req/tx_done handshake with timeout, requeue and a forced idle gap.
module nrf24_event_tx_scheduler
  import nrf24_tx_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REFRESH_CYC = 2000,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] cap_in,
  output logic            tx_req,
  output logic [7:0]      tx_data,
  input  logic            tx_done,
  output logic            busy,
  output logic [3:0]      cur_ch,
  output logic [7:0]      timeout_cnt
);

  localparam int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MAXC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned CNTW = $clog2(MAXC + 1);

  logic [N_CH-1:0] lvl, evt, pend, send, requeue;
  logic [2:0]      seq [N_CH];
  logic [CW-1:0]   rr_ptr, grant;
  logic            found, timeout_hit;
  state_t          state;
  logic [CNTW-1:0] cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nrf24_cap_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .REFRESH_CYC(REFRESH_CYC)) u_cap (
      .clk (clk),
      .rst (rst),
      .cap (cap_in[i]),
      .send(send[i]),
      .lvl (lvl[i]),
      .evt (evt[i])
    );
  end

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(rr_ptr) + k) % N_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  assign timeout_hit = (state == WAIT) && !tx_done && (cnt == CNTW'(TIMEOUT_CYC - 1));

  always_comb begin
    send    = '0;
    requeue = '0;
    if (state == IDLE && found) send[grant] = 1'b1;
    if (timeout_hit) requeue[cur_ch[CW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      cur_ch      <= '0;
      timeout_cnt <= '0;
      for (int unsigned i = 0; i < N_CH; i++) seq[i] <= '0;
    end else begin
      // a new event on the channel being granted wins over its clear
      pend   <= (pend & ~send) | evt | requeue;
      tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state       <= REQ;
            tx_req      <= 1'b1;
            busy        <= 1'b1;
            tx_data     <= make_payload(4'(grant), seq[grant], lvl[grant]);
            seq[grant]  <= seq[grant] + 3'd1;
            cur_ch      <= 4'(grant);
            rr_ptr      <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
            cnt         <= '0;
          end
        end
        REQ: begin
          state <= WAIT;
          cnt   <= cnt + 1'b1;
        end
        WAIT: begin
          if (tx_done) begin
            state <= GAP;
            cnt   <= '0;
          end else if (timeout_hit) begin
            state <= GAP;
            cnt   <= '0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNTW'(GAP_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
